// File: rtl/servo_cmd_sequencer_pkg.sv
// Shared command codes and sequencer state encoding.
// The servo controller imports the same codes so both sides agree on meaning.
package servo_cmd_sequencer_pkg;

    localparam int CODE_W = 3;
    typedef logic [CODE_W-1:0] cmd_code_t;

    localparam cmd_code_t CMD_IDLE      = 3'd1;
    localparam cmd_code_t CMD_DELIVERY  = 3'd2;
    localparam cmd_code_t CMD_TOP       = 3'd3;
    localparam cmd_code_t CMD_INCREMENT = 3'd4;
    localparam cmd_code_t CMD_DECREMENT = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_START = 3'd2,
        S_WAIT_DONE  = 3'd3,
        S_GAP        = 3'd4
    } seq_state_t;

    typedef struct packed {
        logic      valid;
        cmd_code_t code;
    } cmd_req_t;

    function automatic logic cmd_is_valid(input cmd_code_t code);
        return (code >= CMD_IDLE) && (code <= CMD_DECREMENT);
    endfunction

endpackage

// File: rtl/servo_cmd_fifo.sv
// Command queue: power-of-two depth, wrapping pointers, occupancy counter.
// A push into a full queue is taken only when a pop frees the head slot in the same cycle.
module servo_cmd_fifo
    import servo_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  cmd_code_t              wr_data,
    input  logic                   pop,
    output cmd_code_t              rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cmd_code_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/servo_cmd_sequencer.sv
// Arbitrates UART and button requests into a FIFO and issues them one at a time
// to the servo controller, waiting for start/finish and enforcing a gap between commands.
module servo_cmd_sequencer
    import servo_cmd_sequencer_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int START_TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   uart_valid,
    input  logic [2:0]             uart_code,
    input  logic                   btn_up,
    input  logic                   btn_down,
    input  logic                   servo_moving,
    input  logic                   servo_reached,
    output logic [2:0]             servo_state,
    output logic                   servo_cmd_valid,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   err_drop,
    output logic                   err_timeout
);

    localparam int TW = $clog2(START_TIMEOUT) + 1;

    seq_state_t    state;
    seq_state_t    state_nxt;
    logic [TW-1:0] cnt;
    logic          btn_armed;
    logic          btn_up_q;
    logic          btn_down_q;
    logic          up_rise;
    logic          down_rise;
    cmd_req_t      uart_req;
    cmd_req_t      btn_req;
    cmd_req_t      push_req;
    logic          drop;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    cmd_code_t     head;

    // Edge detection stays disarmed for the first cycle after reset so a held button is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_armed  <= 1'b0;
            btn_up_q   <= 1'b0;
            btn_down_q <= 1'b0;
        end else begin
            btn_armed  <= 1'b1;
            btn_up_q   <= btn_up;
            btn_down_q <= btn_down;
        end
    end

    assign up_rise   = btn_armed && btn_up && !btn_up_q;
    assign down_rise = btn_armed && btn_down && !btn_down_q;

    always_comb begin
        uart_req.valid = uart_valid && cmd_is_valid(uart_code);
        uart_req.code  = uart_code;
        btn_req.valid  = up_rise ^ down_rise;
        btn_req.code   = up_rise ? CMD_INCREMENT : CMD_DECREMENT;
        push_req       = uart_req.valid ? uart_req : btn_req;
        drop = (uart_valid && !uart_req.valid)
            || (up_rise && down_rise)
            || (uart_req.valid && btn_req.valid)
            || (push_req.valid && fifo_full && !pop);
    end

    servo_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_req.valid),
        .wr_data (push_req.code),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (q_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Counter restarts on every state change; it times WAIT_START and GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (state != state_nxt)
            cnt <= '0;
        else
            cnt <= cnt + TW'(1);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (pop) state_nxt = S_ISSUE;
            S_ISSUE:      state_nxt = S_WAIT_START;
            S_WAIT_START: begin
                if (servo_moving)
                    state_nxt = S_WAIT_DONE;
                else if (servo_reached || cnt == TW'(START_TIMEOUT - 1))
                    state_nxt = S_GAP;
            end
            S_WAIT_DONE:  if (servo_reached || !servo_moving) state_nxt = S_GAP;
            S_GAP:        if (cnt == TW'(1)) state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        servo_cmd_valid = (state == S_ISSUE);
        pop             = (state == S_IDLE) && !fifo_empty && !servo_moving;
        busy            = (state != S_IDLE) || !fifo_empty;
        err_timeout     = (state == S_WAIT_START) && !servo_moving && !servo_reached
                       && (cnt == TW'(START_TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            servo_state <= CMD_IDLE;
            err_drop    <= 1'b0;
        end else begin
            if (pop)
                servo_state <= head;
            err_drop <= drop;
        end
    end

endmodule

// File: tb/tb_servo_cmd_sequencer.sv
// Bench for servo_cmd_sequencer: vector table, directed corner sequences,
// then randomized traffic against a timestamp-based reference model.
module tb_servo_cmd_sequencer;
    import servo_cmd_sequencer_pkg::*;

    localparam int DEPTH = 4;
    localparam int ST    = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          uart_valid = 1'b0;
    logic [2:0]    uart_code = 3'd0;
    logic          btn_up = 1'b0;
    logic          btn_down = 1'b0;
    logic          servo_moving = 1'b0;
    logic          servo_reached = 1'b0;
    logic [2:0]    servo_state;
    logic          servo_cmd_valid;
    logic          busy;
    logic [CW-1:0] q_count;
    logic          err_drop;
    logic          err_timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    servo_cmd_sequencer #(.DEPTH(DEPTH), .START_TIMEOUT(ST)) dut (
        .clk             (clk),
        .rst             (rst),
        .uart_valid      (uart_valid),
        .uart_code       (uart_code),
        .btn_up          (btn_up),
        .btn_down        (btn_down),
        .servo_moving    (servo_moving),
        .servo_reached   (servo_reached),
        .servo_state     (servo_state),
        .servo_cmd_valid (servo_cmd_valid),
        .busy            (busy),
        .q_count         (q_count),
        .err_drop        (err_drop),
        .err_timeout     (err_timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic step_in(input logic uv, input logic [2:0] uc, input logic bu, input logic bd,
                           input logic mv, input logic rc);
        @(posedge clk);
        #1;
        uart_valid = uv; uart_code = uc; btn_up = bu; btn_down = bd;
        servo_moving = mv; servo_reached = rc;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        uart_valid = 0; uart_code = 0; btn_up = 0; btn_down = 0;
        servo_moving = 0; servo_reached = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic       uv;
        logic [2:0] uc;
        logic       bu, bd, mv, rc;
        logic       ev;
        logic [2:0] es;
        int         eq;
        logic       eb, ed, et;
    } vec_t;
    vec_t tv[$];

    task automatic add(input logic uv, input logic [2:0] uc, input logic bu, input logic bd,
                       input logic mv, input logic rc, input logic ev, input logic [2:0] es,
                       input int eq, input logic eb, input logic ed, input logic et);
        vec_t v;
        v.uv = uv; v.uc = uc; v.bu = bu; v.bd = bd; v.mv = mv; v.rc = rc;
        v.ev = ev; v.es = es; v.eq = eq; v.eb = eb; v.ed = ed; v.et = et;
        tv.push_back(v);
    endtask

    // Reference model: queue plus phase with cycle timestamps for issue and gap start.
    localparam int P_FREE = 0, P_ISSUE = 1, P_START = 2, P_MOVE = 3, P_GAP = 4;
    int   mq[$];
    int   m_ph, m_cur, m_issue, m_gap, cyc;
    logic m_drop, m_pbu, m_pbd;

    function automatic void model_reset();
        mq.delete();
        m_ph = P_FREE; m_cur = 1; m_issue = -100; m_gap = -100;
        m_drop = 0; m_pbu = 0; m_pbd = 0;
    endfunction

    function automatic void model_step(input logic uv, input logic [2:0] uc, input logic bu,
                                       input logic bd, input logic mv, input logic rc);
        logic pop, up_e, dn_e, have, drop;
        int   code;
        pop  = (m_ph == P_FREE) && (mq.size() > 0) && !mv;
        up_e = bu && !m_pbu;
        dn_e = bd && !m_pbd;
        have = 0; drop = 0; code = 0;
        if (uv) begin
            if (uc >= 1 && uc <= 5) begin have = 1; code = int'(uc); end
            else drop = 1;
        end
        if (up_e && dn_e) drop = 1;
        else if (up_e || dn_e) begin
            if (have) drop = 1;
            else begin have = 1; code = up_e ? 4 : 5; end
        end
        if (have && mq.size() == DEPTH && !pop) begin have = 0; drop = 1; end
        case (m_ph)
            P_FREE:  if (pop) begin m_cur = mq.pop_front(); m_ph = P_ISSUE; m_issue = cyc + 1; end
            P_ISSUE: m_ph = P_START;
            P_START: begin
                if (mv) m_ph = P_MOVE;
                else if (rc || (cyc - m_issue) == ST) begin m_ph = P_GAP; m_gap = cyc + 1; end
            end
            P_MOVE:  if (rc || !mv) begin m_ph = P_GAP; m_gap = cyc + 1; end
            default: if (cyc - m_gap == 1) m_ph = P_FREE;
        endcase
        if (have) mq.push_back(code);
        m_drop = drop; m_pbu = bu; m_pbd = bd;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       uv, bu, bd, mv, rc, tmo_exp;
        logic [2:0] uc;
        int         got[$];
        int         exp_codes[4];
        int         k, j;

        // Reset state while reset is held
        #12;
        check("rst q_count", q_count, 0);
        check("rst valid", servo_cmd_valid, 0);
        check("rst state", servo_state, 1);
        check("rst busy", busy, 0);
        check("rst drop", err_drop, 0);
        check("rst timeout", err_timeout, 0);

        //   uv uc bu bd mv rc | ev es eq eb ed et
        add(1, 2, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 1, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0,  1, 2, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0,  0, 2, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0,  0, 2, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 1,  0, 2, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 2, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 2, 0, 1, 0, 0);
        add(1, 7, 0, 0, 0, 0,  0, 2, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 2, 0, 0, 1, 0);
        add(1, 3, 1, 0, 0, 0,  0, 2, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0,  0, 2, 1, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0,  1, 3, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0,  0, 3, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 3, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 3, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 3, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0,  0, 3, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 3, 1, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0,  1, 5, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0,  0, 5, 0, 1, 0, 0);
        add(0, 0, 0, 0, 1, 1,  0, 5, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 5, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 5, 0, 1, 0, 0);
        add(0, 0, 1, 1, 0, 0,  0, 5, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,  0, 5, 0, 0, 1, 0);

        do_reset();
        foreach (tv[i]) begin
            step_in(tv[i].uv, tv[i].uc, tv[i].bu, tv[i].bd, tv[i].mv, tv[i].rc);
            check($sformatf("vec%0d valid", i), servo_cmd_valid, tv[i].ev);
            check($sformatf("vec%0d state", i), servo_state, tv[i].es);
            check($sformatf("vec%0d q_count", i), q_count, tv[i].eq);
            check($sformatf("vec%0d busy", i), busy, tv[i].eb);
            check($sformatf("vec%0d drop", i), err_drop, tv[i].ed);
            check($sformatf("vec%0d timeout", i), err_timeout, tv[i].et);
        end

        // Queue overflow with a stalled servo, then in-order drain
        do_reset();
        step_in(1, 1, 0, 0, 1, 0);
        step_in(1, 4, 0, 0, 1, 0);
        step_in(1, 4, 0, 0, 1, 0);
        step_in(1, 5, 0, 0, 1, 0);
        step_in(1, 3, 0, 0, 1, 0);
        step_in(0, 0, 0, 0, 1, 0);
        check("full drop", err_drop, 1);
        check("full q_count", q_count, DEPTH);
        exp_codes = '{1, 4, 4, 5};
        got.delete();
        for (int n = 0; n < 200 && got.size() < 4; n++) begin
            step_in(0, 0, 0, 0, 0, 0);
            if (servo_cmd_valid) got.push_back(int'(servo_state));
        end
        check("drain count", got.size(), 4);
        for (int n = 0; n < got.size() && n < 4; n++)
            check($sformatf("drain order %0d", n), got[n], exp_codes[n]);

        // Start timeout, then next command after the gap
        do_reset();
        step_in(1, 4, 0, 0, 0, 0);
        step_in(1, 1, 0, 0, 0, 0);
        k = 0;
        while (!servo_cmd_valid && k < 20) begin step_in(0, 0, 0, 0, 0, 0); k++; end
        check("tmo first issue", servo_cmd_valid, 1);
        check("tmo first code", servo_state, 4);
        k = 0;
        do begin step_in(0, 0, 0, 0, 0, 0); k++; end while (!err_timeout && k < 40);
        check("tmo latency", k, ST);
        j = 0;
        do begin step_in(0, 0, 0, 0, 0, 0); j++; end while (!servo_cmd_valid && j < 40);
        check("tmo to next issue", j, 4);
        check("tmo next code", servo_state, 1);

        // Reset while moving with three queued; button held through release
        do_reset();
        step_in(1, 2, 0, 0, 0, 0);
        step_in(1, 3, 0, 0, 0, 0);
        step_in(1, 4, 0, 0, 0, 0);
        step_in(1, 5, 0, 0, 1, 0);
        step_in(0, 0, 0, 0, 1, 0);
        check("pre-rst q_count", q_count, 3);
        check("pre-rst busy", busy, 1);
        #2 rst = 1'b1;
        btn_up = 1'b1;
        #1;
        check("async rst q_count", q_count, 0);
        check("async rst valid", servo_cmd_valid, 0);
        check("async rst busy", busy, 0);
        check("async rst state", servo_state, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        servo_moving = 1'b0;
        for (int n = 0; n < 30; n++) begin
            step_in(0, 0, 1, 0, 0, 0);
            check($sformatf("post-rst valid c%0d", n), servo_cmd_valid, 0);
            check($sformatf("post-rst q_count c%0d", n), q_count, 0);
            check($sformatf("post-rst drop c%0d", n), err_drop, 0);
        end

        // Randomized traffic against the reference model
        do_reset();
        model_reset();
        bu = 0; bd = 0;
        cyc = 0;
        while (cyc < 3000) begin
            uv = ($urandom % 3 == 0);
            uc = 3'($urandom % 8);
            if ($urandom % 6 == 0) bu = ~bu;
            if ($urandom % 6 == 0) bd = ~bd;
            case ((cyc / 500) % 3)
                0:       mv = 1'b0;
                1:       mv = ($urandom % 3 == 0);
                default: mv = ($urandom % 3 != 0);
            endcase
            rc = ($urandom % 16 == 0);
            step_in(uv, uc, bu, bd, mv, rc);
            tmo_exp = (m_ph == P_START) && !mv && !rc && ((cyc - m_issue) == ST);
            check($sformatf("rnd%0d q_count", cyc), q_count, mq.size());
            check($sformatf("rnd%0d valid", cyc), servo_cmd_valid, m_ph == P_ISSUE);
            check($sformatf("rnd%0d state", cyc), servo_state, m_cur);
            check($sformatf("rnd%0d busy", cyc), busy, (m_ph != P_FREE) || (mq.size() > 0));
            check($sformatf("rnd%0d drop", cyc), err_drop, m_drop);
            check($sformatf("rnd%0d timeout", cyc), err_timeout, tmo_exp);
            model_step(uv, uc, bu, bd, mv, rc);
            cyc++;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
